// File: rtl/ps_issue_alu_queue.sv
// ps_issue_alu_queue
// Issue->ALU pipeline stage: a DEPTH-entry circular FIFO of ALU issue packets
// with valid/ready backpressure toward issue and per-wavefront squash.
// Squashed packets stay in their slots as dead entries and are drained from
// the head one per cycle without ever being presented to the ALU.
// Optional feature macro: PS_ISSUE_ALU_BYPASS_EN (same-cycle in->out path
// when the queue is empty). Without it the minimum latency is one cycle.
module ps_issue_alu_queue #(
  parameter int DEPTH  = 2,
  parameter int WFID_W = 6,
  parameter int PC_W   = 32,
  parameter int OPC_W  = 32,
  parameter int IMM0_W = 16,
  parameter int IMM1_W = 32,
  parameter int DEST_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_alu_select,
  output logic                     in_ready,
  input  logic [WFID_W-1:0]        in_wfid,
  input  logic [PC_W-1:0]          in_instr_pc,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [IMM0_W-1:0]        in_imm_value0,
  input  logic [IMM1_W-1:0]        in_imm_value1,
  input  logic [DEST_W-1:0]        in_dest1_addr,
  input  logic [DEST_W-1:0]        in_dest2_addr,
  input  logic                     in_flush,
  input  logic [WFID_W-1:0]        in_flush_wfid,
  output logic                     out_alu_select,
  input  logic                     out_alu_ready,
  output logic [WFID_W-1:0]        out_wfid,
  output logic [PC_W-1:0]          out_instr_pc,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [IMM0_W-1:0]        out_imm_value0,
  output logic [IMM1_W-1:0]        out_imm_value1,
  output logic [DEST_W-1:0]        out_dest1_addr,
  output logic [DEST_W-1:0]        out_dest2_addr,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WFID_W-1:0] wfid;
    logic [PC_W-1:0]   pc;
    logic [OPC_W-1:0]  opcode;
    logic [IMM0_W-1:0] imm0;
    logic [IMM1_W-1:0] imm1;
    logic [DEST_W-1:0] dest1;
    logic [DEST_W-1:0] dest2;
  } pkt_t;

  pkt_t             slot_q [DEPTH];
  pkt_t             slot_d [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;

  pkt_t in_pkt;
  pkt_t head_pkt;
  pkt_t out_pkt;
  logic head_occ;
  logic head_live;
  logic head_flushed;
  logic in_flushed;
  logic bypass_active;
  logic bypass_consume;
  logic pop;
  logic drop_dead;
  logic advance;
  logic push;

  assign in_pkt       = '{in_wfid, in_instr_pc, in_opcode, in_imm_value0,
                          in_imm_value1, in_dest1_addr, in_dest2_addr};
  assign head_pkt     = slot_q[rd_q];
  assign head_occ     = (count_q != '0);
  assign head_live    = live_q[rd_q];
  assign head_flushed = in_flush && (head_pkt.wfid == in_flush_wfid);
  assign in_flushed   = in_flush && (in_wfid == in_flush_wfid);

  // Backpressure comes only from the registered occupancy, never from the ALU side
  assign in_ready = (count_q < CNT_W'(DEPTH));

`ifdef PS_ISSUE_ALU_BYPASS_EN
  assign bypass_active = !head_occ && in_alu_select;
`else
  assign bypass_active = 1'b0;
`endif

  // Present either the head slot or, when bypassing an empty queue, the incoming packet
  always_comb begin
    out_pkt        = head_pkt;
    out_alu_select = head_occ && head_live && !head_flushed;
    if (bypass_active) begin
      out_pkt        = in_pkt;
      out_alu_select = !in_flushed;
    end
  end

  assign out_wfid       = out_pkt.wfid;
  assign out_instr_pc   = out_pkt.pc;
  assign out_opcode     = out_pkt.opcode;
  assign out_imm_value0 = out_pkt.imm0;
  assign out_imm_value1 = out_pkt.imm1;
  assign out_dest1_addr = out_pkt.dest1;
  assign out_dest2_addr = out_pkt.dest2;
  assign out_count      = count_q;

  assign bypass_consume = bypass_active && out_alu_select && out_alu_ready;
  assign pop            = head_occ && out_alu_select && out_alu_ready;
  assign drop_dead      = head_occ && !head_live;
  assign advance        = pop || drop_dead;
  assign push           = in_alu_select && in_ready && !in_flushed && !bypass_consume;

  // Next-state: kill matching slots, write the new packet, advance head on pop or dead drain
  always_comb begin
    slot_d  = slot_q;
    live_d  = live_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (in_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_q[i].wfid == in_flush_wfid) begin
          live_d[i] = 1'b0;
        end
      end
    end
    if (push) begin
      slot_d[wr_q] = in_pkt;
      live_d[wr_q] = 1'b1;
      wr_d         = wr_q + PTR_W'(1);
    end
    if (advance) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push, advance})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with asynchronous active-low clear of pointers, live bits and storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      live_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      live_q  <= live_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ps_issue_alu_queue.sv
// Testbench for ps_issue_alu_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the FIFO.
module tb_ps_issue_alu_queue;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        in_alu_select;
   logic        in_ready;
   logic [5:0]  in_wfid;
   logic [31:0] in_instr_pc;
   logic [31:0] in_opcode;
   logic [15:0] in_imm_value0;
   logic [31:0] in_imm_value1;
   logic [11:0] in_dest1_addr;
   logic [11:0] in_dest2_addr;
   logic        in_flush;
   logic [5:0]  in_flush_wfid;
   logic        out_alu_select;
   logic        out_alu_ready;
   logic [5:0]  out_wfid;
   logic [31:0] out_instr_pc;
   logic [31:0] out_opcode;
   logic [15:0] out_imm_value0;
   logic [31:0] out_imm_value1;
   logic [11:0] out_dest1_addr;
   logic [11:0] out_dest2_addr;
   logic [1:0]  out_count;

   int passCount = 0;
   int checkCount = 0;

   // One queued packet as the model sees it: payload plus a live flag
   typedef struct {
      logic [5:0]  wfid;
      logic [31:0] pc;
      logic [31:0] opc;
      logic [15:0] imm0;
      logic [31:0] imm1;
      logic [11:0] d1;
      logic [11:0] d2;
      bit          live;
   } entry_t;

   entry_t modelQ[$];

   ps_issue_alu_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_alu_select(in_alu_select), .in_ready(in_ready),
      .in_wfid(in_wfid), .in_instr_pc(in_instr_pc), .in_opcode(in_opcode),
      .in_imm_value0(in_imm_value0), .in_imm_value1(in_imm_value1),
      .in_dest1_addr(in_dest1_addr), .in_dest2_addr(in_dest2_addr),
      .in_flush(in_flush), .in_flush_wfid(in_flush_wfid),
      .out_alu_select(out_alu_select), .out_alu_ready(out_alu_ready),
      .out_wfid(out_wfid), .out_instr_pc(out_instr_pc), .out_opcode(out_opcode),
      .out_imm_value0(out_imm_value0), .out_imm_value1(out_imm_value1),
      .out_dest1_addr(out_dest1_addr), .out_dest2_addr(out_dest2_addr),
      .out_count(out_count)
   );

   // Free-running 10ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if observed and expected differ
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle against the model, then advance the model at the edge
   task automatic applyStimulus(input logic sel, input logic [5:0] wfid, input logic [31:0] pc,
                                input logic flush, input logic [5:0] flushWfid, input logic rdy);
      entry_t expPkt;
      bit expSel;
      bit inFlushed;
      bit consumed;
      int sz;
      in_alu_select = sel;
      in_wfid       = wfid;
      in_instr_pc   = pc;
      in_opcode     = $urandom;
      in_imm_value0 = 16'($urandom);
      in_imm_value1 = $urandom;
      in_dest1_addr = 12'($urandom);
      in_dest2_addr = 12'($urandom);
      in_flush      = flush;
      in_flush_wfid = flushWfid;
      out_alu_ready = rdy;
      @(negedge clk);
      sz        = modelQ.size();
      inFlushed = flush && (wfid == flushWfid);
      expSel    = 1'b0;
      consumed  = 1'b0;
      expPkt    = '{default: '0};
      if (sz > 0) begin
         expPkt = modelQ[0];
         expSel = modelQ[0].live && !(flush && modelQ[0].wfid == flushWfid);
      end
`ifdef PS_ISSUE_ALU_BYPASS_EN
      if (sz == 0 && sel) begin
         expPkt   = '{wfid, pc, in_opcode, in_imm_value0, in_imm_value1, in_dest1_addr, in_dest2_addr, 1'b1};
         expSel   = !inFlushed;
         consumed = expSel && rdy;
      end
`endif
      checkOutput("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      checkOutput("out_count", 64'(out_count), 64'(sz));
      checkOutput("out_alu_select", 64'(out_alu_select), 64'(expSel));
      if (expSel) begin
         checkOutput("out_wfid", 64'(out_wfid), 64'(expPkt.wfid));
         checkOutput("out_instr_pc", 64'(out_instr_pc), 64'(expPkt.pc));
         checkOutput("out_opcode", 64'(out_opcode), 64'(expPkt.opc));
         checkOutput("out_imm_value0", 64'(out_imm_value0), 64'(expPkt.imm0));
         checkOutput("out_imm_value1", 64'(out_imm_value1), 64'(expPkt.imm1));
         checkOutput("out_dest1_addr", 64'(out_dest1_addr), 64'(expPkt.d1));
         checkOutput("out_dest2_addr", 64'(out_dest2_addr), 64'(expPkt.d2));
      end
      @(posedge clk);
      if (sz > 0) begin
         if ((modelQ[0].live && expSel && rdy) || !modelQ[0].live) void'(modelQ.pop_front());
      end
      if (flush) begin
         foreach (modelQ[i]) if (modelQ[i].wfid == flushWfid) modelQ[i].live = 1'b0;
      end
      if (sel && sz < DEPTH && !inFlushed && !consumed) begin
         modelQ.push_back('{wfid, pc, in_opcode, in_imm_value0, in_imm_value1, in_dest1_addr, in_dest2_addr, 1'b1});
      end
      #1;
   endtask

   // Idle cycle helper with the ALU ready or stalled
   task automatic idleCycle(input logic rdy);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, rdy);
   endtask

   // Check the all-zero output state seen while and just after reset is applied
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_select"}, 64'(out_alu_select), 64'd0);
      checkOutput({tag, "_count"}, 64'(out_count), 64'd0);
      checkOutput({tag, "_pc"}, 64'(out_instr_pc), 64'd0);
      checkOutput({tag, "_wfid"}, 64'(out_wfid), 64'd0);
      checkOutput({tag, "_opcode"}, 64'(out_opcode), 64'd0);
      checkOutput({tag, "_imm1"}, 64'(out_imm_value1), 64'd0);
   endtask

   // Main sequence: reset, directed scenarios, mid-stream reset, then random traffic
   initial begin
      rst = 1'b0;
      in_alu_select = 1'b0; in_wfid = '0; in_instr_pc = '0; in_opcode = '0;
      in_imm_value0 = '0; in_imm_value1 = '0; in_dest1_addr = '0; in_dest2_addr = '0;
      in_flush = 1'b0; in_flush_wfid = '0; out_alu_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

      // Fill with the ALU stalled: third push is dropped, drain gives 0x100 then 0x104
      applyStimulus(1'b1, 6'd1, 32'h100, 1'b0, 6'd0, 1'b0);
      applyStimulus(1'b1, 6'd1, 32'h104, 1'b0, 6'd0, 1'b0);
      applyStimulus(1'b1, 6'd1, 32'h108, 1'b0, 6'd0, 1'b0);
      checkOutput("fill_head_pc", 64'(out_instr_pc), 64'h100);
      idleCycle(1'b1);
      checkOutput("fill_second_pc", 64'(out_instr_pc), 64'h104);
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Streaming with the ALU always ready
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 6'd2, 32'h300 + 32'(4 * i), 1'b0, 6'd0, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Queue wfid 3 and 5, squash 3 while stalled, then drain
      applyStimulus(1'b1, 6'd3, 32'h400, 1'b0, 6'd0, 1'b0);
      applyStimulus(1'b1, 6'd5, 32'h404, 1'b0, 6'd0, 1'b0);
      applyStimulus(1'b1, 6'd3, 32'h408, 1'b1, 6'd3, 1'b0);
      for (int i = 0; i < 4; i++) idleCycle(1'b1);

      // Flush and push of the same wavefront, then a different wavefront under the same flush
      applyStimulus(1'b1, 6'd7, 32'h500, 1'b1, 6'd7, 1'b1);
      applyStimulus(1'b1, 6'd8, 32'h504, 1'b1, 6'd7, 1'b0);
      checkOutput("flush_push_pc", 64'(out_instr_pc), 64'h504);
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Mid-stream reset with two packets queued
      applyStimulus(1'b1, 6'd9, 32'h600, 1'b0, 6'd0, 1'b0);
      applyStimulus(1'b1, 6'd9, 32'h604, 1'b0, 6'd0, 1'b0);
      in_alu_select = 1'b0;
      rst = 1'b0;
      #1;
      checkResetState("midreset");
      modelQ.delete();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ready_after_midreset", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Random traffic with a small wavefront pool so flushes hit queued packets
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 7)),
                       ($urandom_range(0, 1) == 1));
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
